ni_inject_arbiter: RTL and testbench

//  Shares one endpoint injection port (the NI flit_in / flit_in_wr / credit_out path into a router)

---
 rtl/ni_inject_arbiter_pkg.sv | 32 +++
 rtl/ni_inject_arbiter_if.sv | 36 +++
 rtl/ni_inject_arbiter_rr.sv | 32 +++
 rtl/ni_inject_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_ni_inject_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ni_inject_arbiter_pkg.sv
// rtl/ni_inject_arbiter_pkg.sv - flit layout, FSM state type and credit width helpers
// Purpose: shared definitions for the NI injection arbiter.
//   head_bit/tail_bit/vc_lsb/pay_lsb give field positions in {head, tail, vc_onehot, payload}.
//   cred_w gives the width of a credit counter able to hold 0..B.
package ni_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ni_arb_state_e;

  function automatic int head_bit(input int v, input int fpay);
    return fpay + v + 1;
  endfunction

  function automatic int tail_bit(input int v, input int fpay);
    return fpay + v;
  endfunction

  function automatic int vc_lsb(input int fpay);
    return fpay;
  endfunction

  function automatic int pay_lsb();
    return 0;
  endfunction

  function automatic int cred_w(input int b);
    return $clog2(b + 1);
  endfunction

endpackage

// File: rtl/ni_inject_arbiter_if.sv
// rtl/ni_inject_arbiter_if.sv - source/router side signal bundle of the NI injection arbiter
// Purpose: groups the per-source request handshake and the router-side flit/credit path.
//   req_valid/req_head/req_tail/req_pay : sources -> arbiter, one bit / Fpay slice per source
//   req_ready                           : arbiter -> sources, handshake when valid&ready
//   flit_out/flit_out_wr                : arbiter -> router, {head, tail, vc_onehot, payload}
//   credit_in                           : router -> arbiter, one returned credit per VC bit
//   busy                                : arbiter -> observers, a packet is in progress
// Modports: master (sources/router side), slave (arbiter).
interface ni_inject_arbiter_if #(
  parameter int NREQ = 4,
  parameter int V    = 2,
  parameter int Fpay = 32
);
  localparam int Fw = 2 + V + Fpay;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_head;
  logic [NREQ-1:0]      req_tail;
  logic [NREQ*Fpay-1:0] req_pay;
  logic [NREQ-1:0]      req_ready;
  logic [Fw-1:0]        flit_out;
  logic                 flit_out_wr;
  logic [V-1:0]         credit_in;
  logic                 busy;

  modport master (
    output req_valid, req_head, req_tail, req_pay, credit_in,
    input  req_ready, flit_out, flit_out_wr, busy
  );

  modport slave (
    input  req_valid, req_head, req_tail, req_pay, credit_in,
    output req_ready, flit_out, flit_out_wr, busy
  );

endinterface

// File: rtl/ni_inject_arbiter_rr.sv
// rtl/ni_inject_arbiter_rr.sv - combinational round-robin picker
// Purpose: selects the first asserted request at or after ptr, wrapping past NREQ-1 to 0.
//   req   in  NREQ          request vector
//   ptr   in  $clog2(NREQ)  highest-priority index
//   grant out NREQ          one-hot grant (all zero when no request)
//   any   out 1             some request was granted
module ni_arb_rr #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic                    any
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ni_inject_arbiter.sv
// rtl/ni_inject_arbiter.sv - packet-granular round-robin injection arbiter with per-VC credits
// Purpose: shares one router injection port between NREQ sources. A head flit wins the port
//   (round robin, needs some VC with credit), the packet then owns it until its tail. The VC is
//   chosen at the head (lowest VC with credit) and credits are tracked per VC.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  asynchronous, active-low
//   bus        slave modport of ni_inject_arbiter_if (requests, ready, flit out, credits, busy)
//   stat_flits out NREQ*32 per-source accepted-flit counters   (only with NI_ARB_STATS_EN)
//   stat_stall out 32 cycles a request waited for credit        (only with NI_ARB_STATS_EN)
// Build option: define NI_ARB_STATS_EN to add the statistics counters and ports.
module ni_inject_arbiter
  import ni_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int Fpay = 32
) (
  input  logic clk,
  input  logic reset,
  ni_inject_arbiter_if.slave bus
`ifdef NI_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0] stat_flits,
  output logic [31:0]        stat_stall
`endif
);
  localparam int Fw = 2 + V + Fpay;
  localparam int PW = $clog2(NREQ);
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int CW = cred_w(B);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_SEND = SEND;

  logic [0:0]             state_q, state_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [VW-1:0]          vc_q, vc_d;
  logic [V-1:0][CW-1:0]   credit_q, credit_d;
  logic [Fw-1:0]          flit_q, flit_d;
  logic                   wr_q, wr_d;

  logic [V-1:0]    vc_ok;
  logic [V-1:0]    dec;
  logic [VW-1:0]   free_vc;
  logic            free_any;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick_grant;
  logic            pick_any;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] hs;
  logic            hs_any;
  logic [PW-1:0]   hs_idx;
  logic [VW-1:0]   hs_vc;
  logic [V-1:0]    vc_oh;
  logic            sel_head;
  logic            sel_tail;
  logic [Fpay-1:0] sel_pay;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lowest-indexed VC that still has downstream space.
  always_comb begin
    free_vc  = '0;
    free_any = 1'b0;
    vc_ok    = '0;
    for (int v = 0; v < V; v++) begin
      vc_ok[v] = (credit_q[v] != '0);
    end
    for (int v = V - 1; v >= 0; v--) begin
      if (vc_ok[v]) begin
        free_vc  = VW'(v);
        free_any = 1'b1;
      end
    end
  end

  assign cand = bus.req_valid & bus.req_head;

  ni_arb_rr #(.NREQ(NREQ)) u_rr (
    .req   (cand),
    .ptr   (rr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Ready is forced low while reset is held so nothing is accepted during reset.
  always_comb begin
    ready = '0;
    if (state_q == ST_IDLE) begin
      if (free_any && pick_any) begin
        ready = pick_grant;
      end
    end else begin
      ready[owner_q] = vc_ok[vc_q];
    end
    ready = ready & {NREQ{reset}};
  end

  assign hs     = ready & bus.req_valid;
  assign hs_any = |hs;
  assign hs_vc  = (state_q == ST_IDLE) ? free_vc : vc_q;

  always_comb begin
    hs_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        hs_idx = PW'(i);
      end
    end
  end

  assign sel_head = bus.req_head[hs_idx];
  assign sel_tail = bus.req_tail[hs_idx];
  assign sel_pay  = bus.req_pay[hs_idx*Fpay +: Fpay];
  assign vc_oh    = V'(1) << hs_vc;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    vc_d    = vc_q;
    flit_d  = flit_q;
    wr_d    = 1'b0;
    if (hs_any) begin
      wr_d                          = 1'b1;
      flit_d                        = '0;
      flit_d[head_bit(V, Fpay)]     = sel_head;
      flit_d[tail_bit(V, Fpay)]     = sel_tail;
      flit_d[vc_lsb(Fpay) +: V]     = vc_oh;
      flit_d[pay_lsb() +: Fpay]     = sel_pay;
      if (state_q == ST_IDLE) begin
        if (sel_tail) begin
          rr_d = ptr_inc(hs_idx);
        end else begin
          state_d = ST_SEND;
          owner_d = hs_idx;
          vc_d    = free_vc;
        end
      end else if (sel_tail) begin
        state_d = ST_IDLE;
        rr_d    = ptr_inc(owner_q);
      end
    end
  end

  // A return and a send on the same VC in one cycle cancel out; a return at B is dropped.
  always_comb begin
    dec      = '0;
    credit_d = credit_q;
    for (int v = 0; v < V; v++) begin
      dec[v] = hs_any && (hs_vc == VW'(v));
      if (dec[v] && !bus.credit_in[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (bus.credit_in[v] && !dec[v] && (credit_q[v] != CW'(B))) begin
        credit_d[v] = credit_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      vc_q    <= '0;
      flit_q  <= '0;
      wr_q    <= 1'b0;
      for (int v = 0; v < V; v++) begin
        credit_q[v] <= CW'(B);
      end
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      vc_q     <= vc_d;
      flit_q   <= flit_d;
      wr_q     <= wr_d;
      credit_q <= credit_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.flit_out    = flit_q;
  assign bus.flit_out_wr = wr_q;
  assign bus.busy        = (state_q == ST_SEND);

  a_head_in_send: assert property (@(posedge clk) disable iff (!reset)
    !(state_q == ST_SEND && hs_any && bus.req_head[owner_q]));

  for (genvar gv = 0; gv < V; gv++) begin : g_cred_chk
    a_credit_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(bus.credit_in[gv] && !dec[gv] && credit_q[gv] == CW'(B)));
  end

`ifdef NI_ARB_STATS_EN
  logic [NREQ-1:0][31:0] stat_flits_q;
  logic [31:0]           stat_stall_q;
  logic                  stall_ev;

  // Someone could move a flit this cycle but no credit is available for it.
  assign stall_ev = (state_q == ST_IDLE) ? (|cand && !free_any)
                                         : (bus.req_valid[owner_q] && !vc_ok[vc_q]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_flits_q <= '0;
      stat_stall_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          stat_flits_q[i] <= stat_flits_q[i] + 32'd1;
        end
      end
      if (stall_ev) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_flits = stat_flits_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// tb/tb_ni_inject_arbiter.sv - randomized self-checking bench for ni_inject_arbiter
module tb_ni_inject_arbiter;
  localparam int NREQ = 4;
  localparam int V    = 2;
  localparam int B    = 4;
  localparam int FPAY = 32;
  localparam int FW   = 2 + V + FPAY;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ni_inject_arbiter_if #(.NREQ(NREQ), .V(V), .Fpay(FPAY)) bus ();

`ifdef NI_ARB_STATS_EN
  logic [NREQ*32-1:0] stat_flits;
  logic [31:0]        stat_stall;
`endif

  ni_inject_arbiter #(.NREQ(NREQ), .V(V), .B(B), .Fpay(FPAY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef NI_ARB_STATS_EN
    ,
    .stat_flits (stat_flits),
    .stat_stall (stat_stall)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: which source owns the port, next priority source, credits per VC.
  int              m_owner;
  int              m_vc;
  int              m_rr;
  int              m_cred [V];
  logic            exp_wr;
  logic [FW-1:0]   exp_flit;

  // Source generators: current packet length, position in it, offered flag and payload.
  int              s_len   [NREQ];
  int              s_pos   [NREQ];
  logic            s_valid [NREQ];
  logic [FPAY-1:0] s_pay   [NREQ];

  int max_len;
  int offer_pct;
  int credit_pct;

  task automatic model_reset();
    m_owner  = -1;
    m_vc     = 0;
    m_rr     = 0;
    for (int v = 0; v < V; v++) m_cred[v] = B;
    exp_wr   = 1'b0;
    exp_flit = '0;
    for (int s = 0; s < NREQ; s++) begin
      s_len[s]   = 0;
      s_pos[s]   = 0;
      s_valid[s] = 1'b0;
      s_pay[s]   = $urandom;
    end
  endtask

  task automatic drive_inputs();
    for (int s = 0; s < NREQ; s++) begin
      if (s_len[s] == 0 && $urandom_range(0, 99) < 50) begin
        s_len[s] = $urandom_range(1, max_len);
        s_pos[s] = 0;
      end
      if (!s_valid[s] && s_len[s] != 0 && $urandom_range(0, 99) < offer_pct) s_valid[s] = 1'b1;
      bus.req_valid[s]             = s_valid[s];
      bus.req_head[s]              = (s_pos[s] == 0);
      bus.req_tail[s]              = (s_pos[s] == s_len[s] - 1);
      bus.req_pay[s*FPAY +: FPAY]  = s_pay[s];
    end
    for (int v = 0; v < V; v++)
      bus.credit_in[v] = (m_cred[v] < B) && ($urandom_range(0, 99) < credit_pct);
  endtask

  task automatic model_step();
    logic [NREQ-1:0] er;
    logic [V-1:0]    oh;
    int g, fv, hvc, idx;
    logic hd, tl;
    er = '0; g = -1; fv = -1; hvc = 0;
    if (m_owner < 0) begin
      for (int v = V - 1; v >= 0; v--) if (m_cred[v] > 0) fv = v;
      if (fv >= 0) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (g < 0 && s_valid[idx] && s_pos[idx] == 0) g = idx;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      hvc = (fv < 0) ? 0 : fv;
    end else begin
      if (m_cred[m_vc] > 0) er[m_owner] = 1'b1;
      hvc = m_vc;
    end
    check_eq("req_ready", 64'(bus.req_ready), 64'(er));
    exp_wr = 1'b0;
    for (int s = 0; s < NREQ; s++) begin
      if (er[s] && s_valid[s]) begin
        hd = (s_pos[s] == 0);
        tl = (s_pos[s] == s_len[s] - 1);
        oh = '0;
        oh[hvc] = 1'b1;
        exp_wr   = 1'b1;
        exp_flit = {hd, tl, oh, s_pay[s]};
        m_cred[hvc]--;
        if (m_owner < 0) begin
          if (tl) m_rr = (s + 1) % NREQ;
          else begin
            m_owner = s;
            m_vc    = hvc;
          end
        end else if (tl) begin
          m_owner = -1;
          m_rr    = (s + 1) % NREQ;
        end
        s_valid[s] = 1'b0;
        s_pos[s]++;
        s_pay[s] = $urandom;
        if (s_pos[s] == s_len[s]) begin
          s_len[s] = 0;
          s_pos[s] = 0;
        end
      end
    end
    for (int v = 0; v < V; v++) if (bus.credit_in[v]) m_cred[v]++;
  endtask

  task automatic check_outputs();
    check_eq("flit_out_wr", 64'(bus.flit_out_wr), 64'(exp_wr));
    check_eq("flit_out", 64'(bus.flit_out), 64'(exp_flit));
    check_eq("busy", 64'(bus.busy), 64'(m_owner >= 0));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive_inputs();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
    end
  endtask

  // Reset with every source presenting a head: nothing may be accepted, outputs cleared.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = '1;
    bus.req_head  = '1;
    bus.req_tail  = '0;
    bus.credit_in = '0;
    #1;
    check_eq({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check_eq({tag, "_flit_out_wr"}, 64'(bus.flit_out_wr), 64'd0);
    check_eq({tag, "_flit_out"}, 64'(bus.flit_out), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.req_head  = '0;
    reset = 1'b1;
  endtask

  // All sources offer a fresh head together: source 0 must win after reset.
  task automatic all_heads_now(input int len);
    for (int s = 0; s < NREQ; s++) begin
      s_len[s]   = len;
      s_pos[s]   = 0;
      s_valid[s] = 1'b1;
    end
  endtask

  initial begin
    int budget;
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_head  = '0;
    bus.req_tail  = '0;
    bus.req_pay   = '0;
    bus.credit_in = '0;
    model_reset();
    apply_reset("rst0");

    max_len = 3; offer_pct = 70; credit_pct = 60;
    all_heads_now(3);
    run(400);

    max_len = 1; offer_pct = 100; credit_pct = 100;
    run(200);

    max_len = 6; offer_pct = 90; credit_pct = 15;
    run(400);

    budget = 200;
    while (m_owner < 0 && budget > 0) begin
      run(1);
      budget--;
    end
    check_eq("busy_before_reset", 64'(bus.busy), 64'd1);
    apply_reset("rst_mid");

    max_len = 4; offer_pct = 80; credit_pct = 40;
    all_heads_now(2);
    run(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
